bcd_to_bin_decoder: RTL

BCD_TO_BIN_DECODER -- requirements
Module: bcd_to_bin_decoder

---
 rtl/bcd_to_bin_decoder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/bcd_to_bin_decoder.sv
// Multi-cycle packed-BCD to binary converter built on reverse double-dabble.
// One bit is shifted per cycle; invalid digits short-circuit straight to the result.
module bcd_to_bin_decoder #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in_bcd,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic                  out_gt255,
    output logic                  out_err,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Any nibble above 9 makes the whole word an illegal BCD value.
    function automatic logic bcd_has_bad_digit(input logic [BCD_W-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd[4*d +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // One reverse double-dabble step: shift {bcd, bin} right, then pull
    // every digit that landed at 8 or above back down by 3.
    function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] work);
        logic [WORK_W-1:0] shifted;
        shifted = {1'b0, work[WORK_W-1:1]};
        for (int d = 0; d < DIGITS; d++) begin
            if (shifted[BIN_W + 4*d +: 4] >= 4'd8) begin
                shifted[BIN_W + 4*d +: 4] = shifted[BIN_W + 4*d +: 4] - 4'd3;
            end else begin
                shifted[BIN_W + 4*d +: 4] = shifted[BIN_W + 4*d +: 4];
            end
        end
        return shifted;
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WORK_W-1:0]  work_r;
    logic [WORK_W-1:0]  work_step_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [BIN_W-1:0]   out_bin_r;
    logic               out_gt255_r;
    logic               out_err_r;
    logic [BIN_W-1:0]   bin_next_s;
    logic               gt255_s;
    logic               in_ready_s;
    logic               in_hs_s;
    logic               load_s;
    logic               load_err_s;
    logic               step_s;
    logic               last_s;

    assign work_step_s = dabble_step(work_r);
    assign bin_next_s  = work_step_s[BIN_W-1:0];
    assign gt255_s     = (32'(bin_next_s) > 32'd255);

    // Handshake qualification; reset suppresses acceptance immediately.
    always_comb begin
        in_ready_s = 1'b0;
        if ((state_r == ST_IDLE) && !rst) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        in_hs_s = in_valid & in_ready_s;
    end

    // Next-state and datapath control decode.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        load_err_s  = 1'b0;
        step_s      = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_hs_s) begin
                    if (bcd_has_bad_digit(in_bcd)) begin
                        load_err_s  = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        load_s      = 1'b1;
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                step_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    last_s      = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Working register and iteration counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_r <= {WORK_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (load_s) begin
            work_r <= {in_bcd, {BIN_W{1'b0}}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (step_s) begin
            work_r <= work_step_s;
            cnt_r  <= cnt_r + CNT_W'(1);
        end else begin
            work_r <= work_r;
            cnt_r  <= cnt_r;
        end
    end

    // Result registers only change when DONE is entered, so partial
    // conversions never become visible and results hold while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_bin_r   <= {BIN_W{1'b0}};
            out_gt255_r <= 1'b0;
            out_err_r   <= 1'b0;
        end else if (load_err_s) begin
            out_bin_r   <= {BIN_W{1'b0}};
            out_gt255_r <= 1'b0;
            out_err_r   <= 1'b1;
        end else if (last_s) begin
            out_bin_r   <= bin_next_s;
            out_gt255_r <= gt255_s;
            out_err_r   <= 1'b0;
        end else begin
            out_bin_r   <= out_bin_r;
            out_gt255_r <= out_gt255_r;
            out_err_r   <= out_err_r;
        end
    end

    // Output drive; reset forces every output low before the first edge.
    always_comb begin
        in_ready = in_ready_s;
        if (rst) begin
            out_valid = 1'b0;
            out_bin   = {BIN_W{1'b0}};
            out_gt255 = 1'b0;
            out_err   = 1'b0;
        end else begin
            out_valid = (state_r == ST_DONE);
            out_bin   = out_bin_r;
            out_gt255 = out_gt255_r;
            out_err   = out_err_r;
        end
    end

endmodule
